iir_coeff_loader: RTL and testbench

Host-side configuration sequencer for the IIR lowpass filter coefficient port. It receives a framed byte stream (valid/ready) and assembles 16-bit coefficient words into a shadow buffer. The frame checksum and address range are validated before any filter write. Only a validated frame is committed, as one contiguous burst on the filter's c_we/c_addr/c_in port. While c_we is high the filter's sample sequencing is frozen, so the commit burst is kept to exactly count cycles.

---
 rtl/iir_coeff_loader.sv | 191 +++++++++++++++++++
 tb/tb_iir_coeff_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_coeff_loader.sv
// Purpose: parses a framed host byte stream, stages coefficients in a shadow buffer, and commits validated frames to the IIR filter.
// Latency: the commit burst starts on the cycle after the CSUM byte, lasts COUNT cycles, and done follows on the next cycle.
// Backpressure: in_ready is low during COMMIT and for the single ERR cycle; bytes are accepted on in_valid & in_ready.
module iir_coeff_loader #(
    parameter int         ORD = 10,
    parameter int         CW  = 16,
    parameter int         AW  = 5,
    parameter int         TMO = 1000,
    parameter logic [7:0] HDR = 8'hA5
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [CW-1:0] c_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam int NUM_COEFF = 3*ORD/2 + ORD/2;
    localparam int IW        = $clog2(NUM_COEFF);
    localparam int TW        = $clog2(TMO);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_COUNT, S_DHI, S_DLO, S_CSUM, S_COMMIT, S_ERR
    } state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_c_we;
    logic [AW-1:0]   r_c_addr;
    logic [CW-1:0]   r_c_in;
    logic            r_done;
    logic            r_err;
    logic [1:0]      r_err_code;
    logic [7:0]      r_start;
    logic [7:0]      r_count;
    logic [7:0]      r_k;
    logic [7:0]      r_i;
    logic [7:0]      r_hi;
    logic [7:0]      r_csum;
    logic [TW-1:0]   r_tmo;
    logic [CW-1:0]   r_shadow [NUM_COEFF];

    logic            w_acc;
    logic            w_open;
    logic [8:0]      w_range_sum;
    logic [7:0]      w_wr_ptr;
    logic [7:0]      w_rd_ptr;

    assign w_acc       = in_valid & r_in_ready;
    assign w_open      = (r_state == S_START) || (r_state == S_COUNT) || (r_state == S_DHI) ||
                         (r_state == S_DLO)   || (r_state == S_CSUM);
    // 9-bit sum so a large START cannot wrap back into range
    assign w_range_sum = {1'b0, r_start} + {1'b0, in_data};
    assign w_wr_ptr    = r_start + r_k;
    assign w_rd_ptr    = r_start + r_i;

    assign in_ready = r_in_ready;
    assign c_we     = r_c_we;
    assign c_addr   = r_c_addr;
    assign c_in     = r_c_in;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;

    // Shadow buffer: captures each assembled word as its low byte arrives; deliberately not reset
    always_ff @(posedge clk) begin
        if (r_state == S_DLO && w_acc) begin
            r_shadow[IW'(w_wr_ptr)] <= {r_hi, in_data};
        end
    end

    // Frame parser, commit sequencer and inter-byte timeout with registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_c_we     <= 1'b0;
            r_c_addr   <= '0;
            r_c_in     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_start    <= 8'd0;
            r_count    <= 8'd0;
            r_k        <= 8'd0;
            r_i        <= 8'd0;
            r_hi       <= 8'd0;
            r_csum     <= 8'd0;
            r_tmo      <= '0;
        end else begin
            r_c_we <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    r_tmo      <= '0;
                    r_k        <= 8'd0;
                    r_i        <= 8'd0;
                    if (w_acc && in_data == HDR) begin
                        r_state <= S_START;
                        r_csum  <= HDR;
                    end
                end
                S_START: if (w_acc) begin
                    r_start <= in_data;
                    r_csum  <= r_csum ^ in_data;
                    r_state <= S_COUNT;
                end
                S_COUNT: if (w_acc) begin
                    r_count <= in_data;
                    r_csum  <= r_csum ^ in_data;
                    if (in_data == 8'd0 || w_range_sum > 9'(NUM_COEFF)) begin
                        r_state    <= S_ERR;
                        r_in_ready <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= 2'b10;
                    end else begin
                        r_state <= S_DHI;
                    end
                end
                S_DHI: if (w_acc) begin
                    r_hi    <= in_data;
                    r_csum  <= r_csum ^ in_data;
                    r_state <= S_DLO;
                end
                S_DLO: if (w_acc) begin
                    r_csum  <= r_csum ^ in_data;
                    r_k     <= r_k + 8'd1;
                    r_state <= (r_k + 8'd1 == r_count) ? S_CSUM : S_DHI;
                end
                S_CSUM: if (w_acc) begin
                    if (in_data == r_csum) begin
                        // first write issues on entry so the burst is exactly COUNT cycles
                        r_state    <= S_COMMIT;
                        r_in_ready <= 1'b0;
                        r_c_we     <= 1'b1;
                        r_c_addr   <= AW'(w_rd_ptr);
                        r_c_in     <= r_shadow[IW'(w_rd_ptr)];
                        r_i        <= r_i + 8'd1;
                    end else begin
                        r_state    <= S_ERR;
                        r_in_ready <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= 2'b01;
                    end
                end
                S_COMMIT: begin
                    if (r_i == r_count) begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b1;
                        r_done     <= 1'b1;
                    end else begin
                        r_c_we   <= 1'b1;
                        r_c_addr <= AW'(w_rd_ptr);
                        r_c_in   <= r_shadow[IW'(w_rd_ptr)];
                        r_i      <= r_i + 8'd1;
                    end
                end
                S_ERR: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
            // an accepted byte always beats the timeout in the same cycle
            if (w_open) begin
                if (w_acc) begin
                    r_tmo <= '0;
                end else if (r_tmo == TW'(TMO-1)) begin
                    r_state    <= S_ERR;
                    r_in_ready <= 1'b0;
                    r_err      <= 1'b1;
                    r_err_code <= 2'b11;
                    r_tmo      <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Bench for iir_coeff_loader: directed frames plus randomized frames against a frame-level reference model.
module tb_iir_coeff_loader;

    localparam int NUMC = 20;
    localparam int TMO  = 1000;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        c_we;
    logic [4:0]  c_addr;
    logic [15:0] c_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    iir_coeff_loader dut (
        .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .c_we(c_we), .c_addr(c_addr), .c_in(c_in), .busy(busy), .done(done), .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // stimulus and model state
    logic [7:0]  tx_q[$];
    int          tx_gap[$];
    logic [15:0] wbuf[NUMC];
    logic [20:0] exp_q[$];
    int          exp_kind;   // 0 nothing, 1 commit, 2 error
    logic [1:0]  exp_code;

    // monitor state
    logic [20:0] wq[$];
    int          wcyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          done_cyc = 0;
    int          rdy_viol = 0;
    logic [1:0]  err_seen = 2'b00;

    always @(negedge clk) begin
        cyc++;
        if (nrst) begin
            if (c_we) begin
                wq.push_back({c_addr, c_in});
                wcyc.push_back(cyc);
                if (in_ready || !busy) rdy_viol++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) begin
                err_cnt++;
                err_seen = err_code;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    // frame-level reference: locate header, apply range and checksum rules, list expected writes
    task automatic model();
        int p, st, cn, last;
        logic [7:0] x;
        exp_q.delete();
        exp_kind = 0;
        exp_code = 2'b00;
        p = 0;
        while (p < tx_q.size() && tx_q[p] != 8'hA5) p++;
        if (p + 2 >= tx_q.size()) return;
        st = int'(tx_q[p+1]);
        cn = int'(tx_q[p+2]);
        if (cn == 0 || st + cn > NUMC) begin
            exp_kind = 2;
            exp_code = 2'b10;
            return;
        end
        last = p + 2 + 2*cn;
        if (last + 1 >= tx_q.size()) return;
        x = 8'h00;
        for (int i = p; i <= last; i++) x ^= tx_q[i];
        if (x != tx_q[last+1]) begin
            exp_kind = 2;
            exp_code = 2'b01;
            return;
        end
        exp_kind = 1;
        for (int k = 0; k < cn; k++)
            exp_q.push_back({5'(st + k), tx_q[p+3+2*k], tx_q[p+4+2*k]});
    endtask

    task automatic push_b(input logic [7:0] b, input int maxgap);
        tx_q.push_back(b);
        tx_gap.push_back(int'($urandom_range(0, maxgap)));
    endtask

    // builds a frame from wbuf[0..cn-1]; out-of-range frames stop after COUNT
    task automatic build(input int st, input int cn, input bit bad_csum, input int n_garb, input int maxgap);
        logic [7:0] x, b;
        tx_q.delete();
        tx_gap.delete();
        for (int g = 0; g < n_garb; g++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            push_b(b, maxgap);
        end
        x = 8'hA5 ^ 8'(st) ^ 8'(cn);
        push_b(8'hA5, maxgap);
        push_b(8'(st), maxgap);
        push_b(8'(cn), maxgap);
        if (cn != 0 && st + cn <= NUMC) begin
            for (int k = 0; k < cn; k++) begin
                push_b(wbuf[k][15:8], maxgap);
                push_b(wbuf[k][7:0], maxgap);
                x ^= wbuf[k][15:8] ^ wbuf[k][7:0];
            end
            if (bad_csum) x ^= 8'($urandom_range(1, 255));
            push_b(x, maxgap);
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NUMC; k++) wbuf[k] = 16'($urandom);
    endtask

    // caller sits just after a falling edge; returns just after the falling edge following acceptance
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_eq("rdy_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_all();
        for (int i = 0; i < tx_q.size(); i++) begin
            repeat (tx_gap[i]) @(negedge clk);
            send_byte(tx_q[i]);
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        wcyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        rdy_viol = 0;
    endtask

    task automatic run_frame(input string tag);
        int n, nw;
        model();
        clear_mon();
        send_all();
        n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check_eq({tag, "/done_cnt"}, done_cnt, (exp_kind == 1) ? 1 : 0);
        check_eq({tag, "/err_cnt"}, err_cnt, (exp_kind == 2) ? 1 : 0);
        if (exp_kind == 2) check_eq({tag, "/err_code"}, err_seen, exp_code);
        check_eq({tag, "/n_writes"}, wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
            check_eq({tag, "/c_addr"}, wq[i][20:16], exp_q[i][20:16]);
            check_eq({tag, "/c_in"}, wq[i][15:0], exp_q[i][15:0]);
        end
        nw = wq.size();
        if (nw > 0 && nw == exp_q.size()) begin
            check_eq({tag, "/burst_len"}, wcyc[nw-1] - wcyc[0] + 1, nw);
            check_eq({tag, "/done_cycle"}, done_cyc, wcyc[nw-1] + 1);
        end
        check_eq({tag, "/rdy_in_commit"}, rdy_viol, 0);
        check_eq({tag, "/busy_after"}, busy, 0);
    endtask

    initial begin
        int n, st, cn, r, ng;
        logic [20:0] w0;

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {in_ready, c_we, busy, done, err, err_code, c_addr, c_in}, 0);
        nrst = 1'b1;
        @(negedge clk);
        check_eq("rst_rdy", {in_ready, busy}, 2'b10);

        // single word frame
        tx_q   = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h82};
        tx_gap = '{0, 0, 0, 0, 0, 0};
        run_frame("s1");
        w0 = (wq.size() > 0) ? wq[0] : '0;
        check_eq("s1_word", w0, {5'd0, 16'h1234});

        // full table load
        for (int k = 0; k < NUMC; k++) wbuf[k] = 16'h0100 + 16'(k);
        build(0, NUMC, 1'b0, 0, 0);
        run_frame("full");
        w0 = (wq.size() == NUMC) ? wq[NUMC-1] : '0;
        check_eq("full_last", w0, {5'd19, 16'h0113});

        // bad checksum, then a good frame; err_code holds through the good frame
        tx_q   = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h83};
        tx_gap = '{0, 0, 0, 0, 0, 0};
        run_frame("badcs");
        fill_rand();
        build(3, 2, 1'b0, 0, 1);
        run_frame("after_bad");
        check_eq("code_held", err_code, 2'b01);

        // range violations and the exact-fit boundary
        tx_q   = '{8'hA5, 8'h12, 8'h03};
        tx_gap = '{0, 0, 0};
        run_frame("rng18p3");
        tx_q   = '{8'hA5, 8'h00, 8'h00};
        tx_gap = '{0, 0, 0};
        run_frame("rng_cnt0");
        fill_rand();
        build(16, 4, 1'b0, 0, 0);
        run_frame("rng_edge");

        // inter-byte timeout
        tx_q   = '{8'hA5, 8'h00, 8'h01, 8'h12};
        tx_gap = '{0, 0, 0, 0};
        clear_mon();
        send_all();
        n = 0;
        while (!err && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("tmo_cycles", n, TMO);
        check_eq("tmo_code", err_code, 2'b11);
        repeat (3) @(negedge clk);
        check_eq("tmo_writes", wq.size(), 0);
        check_eq("tmo_idle", {in_ready, busy}, 2'b10);

        // slow frames just inside the timeout, including a byte landing on the last count
        fill_rand();
        build(5, 2, 1'b0, 0, 0);
        for (int i = 0; i < tx_gap.size(); i++) tx_gap[i] = TMO - 2;
        run_frame("gap998");
        build(7, 1, 1'b0, 0, 0);
        for (int i = 0; i < tx_gap.size(); i++) tx_gap[i] = TMO - 1;
        run_frame("gap999");

        // leading garbage is ignored
        fill_rand();
        build(2, 3, 1'b0, 0, 0);
        tx_q.push_front(8'h5A);
        tx_q.push_front(8'hFF);
        tx_q.push_front(8'h00);
        for (int i = 0; i < 3; i++) tx_gap.push_front(0);
        run_frame("garbage");

        // randomized frames
        for (int it = 0; it < 25; it++) begin
            fill_rand();
            r  = int'($urandom_range(0, 9));
            st = int'($urandom_range(0, NUMC - 1));
            cn = int'($urandom_range(1, NUMC - st));
            if (r == 0) cn = 0;
            if (r == 1) begin
                st = int'($urandom_range(0, 30));
                cn = (st >= NUMC) ? int'($urandom_range(1, 10)) : NUMC + 1 - st + int'($urandom_range(0, 3));
            end
            ng = int'($urandom_range(0, 2));
            build(st, cn, (r == 2 || r == 3), ng, 2);
            run_frame("rand");
        end

        // reset in the middle of a commit burst
        for (int k = 0; k < NUMC; k++) wbuf[k] = 16'hBEEF ^ 16'(k);
        build(0, NUMC, 1'b0, 0, 0);
        clear_mon();
        send_all();
        n = 0;
        while (wq.size() < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2 nrst = 1'b0;
        #1 check_eq("rst_mid_commit", {c_we, busy, done, err, in_ready}, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_eq("rst_release", {in_ready, busy, c_we}, 3'b100);
        fill_rand();
        build(9, 3, 1'b0, 1, 1);
        run_frame("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
